// File: rtl/sort_pkg.sv
// sort_pkg: shared definitions for the sort result checker slice.
//   DATA_W_DEF / CNT_W_DEF / SUM_W_DEF : default element, index and accumulator widths
//   sort_state_e                       : checker FSM state encoding
//   median_idx()                       : index of the lower median for a frame length
package sort_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;
  localparam int SUM_W_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } sort_state_e;

  // Lower median of an n-element frame: floor((n-1)/2). Only called with n != 0.
  function automatic logic [63:0] median_idx(input logic [63:0] len);
    return (len - 64'd1) >> 1;
  endfunction

endpackage

// File: rtl/sort_result_checker_if.sv
// sort_result_checker_if: sorted-word stream from the sorter into the checker.
//   in_valid : qualifies in_data this cycle (no backpressure)
//   in_data  : sorted element
//   n        : frame length, meaningful on a frame's first element
// Modports: master = sorter side (drives), slave = checker side (receives).
interface sort_result_checker_if
  import sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  n;

  modport master (output in_valid, in_data, n);
  modport slave  (input  in_valid, in_data, n);

endinterface

// File: rtl/sort_stat_accum.sv
// sort_stat_accum: per-frame datapath of the result checker.
//   clk, reset       : clock, synchronous active-low reset
//   accept           : an element is consumed this cycle
//   first            : the consumed element is element 0 of a new frame
//   idx              : index of the consumed element within its frame
//   in_data          : the consumed element
//   sum              : running unsigned sum of the frame
//   order_err        : some element exceeded its predecessor (sticky per frame)
//   err_index        : index of the first violating element, 0 if none
module sort_stat_accum
  import sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              first,
  input  logic [CNT_W-1:0]  idx,
  input  logic [DATA_W-1:0] in_data,
  output logic [SUM_W-1:0]  sum,
  output logic              order_err,
  output logic [CNT_W-1:0]  err_index
);

  logic [DATA_W-1:0] prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low, so it only acts on a clock edge.
    if (!reset) begin
      prev      <= '0;
      sum       <= '0;
      order_err <= 1'b0;
      err_index <= '0;
    end else if (accept) begin
      prev <= in_data;
      if (first) begin
        sum       <= SUM_W'(in_data);
        order_err <= 1'b0;
        err_index <= '0;
      end else begin
        sum <= sum + SUM_W'(in_data);
        // Only the first violation of a frame is recorded.
        if ((in_data > prev) && !order_err) begin
          order_err <= 1'b1;
          err_index <= idx;
        end
      end
    end
  end

endmodule

// File: rtl/sort_result_checker.sv
// sort_result_checker: checks that a sorter's output frame is non-increasing and
// summarises it without buffering.
//   clk, reset  : clock, synchronous active-low reset
//   s_in        : slave stream (in_valid, in_data, n)
//   done        : one-cycle pulse, frame results valid
//   count       : elements accepted in the last frame
//   max_val     : first element of the frame
//   min_val     : last element of the frame
//   median_val  : element at index floor((n-1)/2)
//   sum         : unsigned sum of all elements
//   order_err   : some element exceeded its predecessor
//   err_index   : index of the first violating element, 0 if none
module sort_result_checker
  import sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  sort_result_checker_if.slave  s_in,
  output logic                  done,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_W-1:0]     max_val,
  output logic [DATA_W-1:0]     min_val,
  output logic [DATA_W-1:0]     median_val,
  output logic [SUM_W-1:0]      sum,
  output logic                  order_err,
  output logic [CNT_W-1:0]      err_index
);

  sort_state_e      state;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] med_idx_q;
  logic [CNT_W-1:0] start_med_idx;

  logic start_ok;
  logic accept;
  logic first;

  // A frame may start from IDLE or directly from DONE (back-to-back frames).
  assign start_ok      = s_in.in_valid && (s_in.n != '0);
  assign start_med_idx = CNT_W'(median_idx(64'(s_in.n)));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    accept = 1'b0;
    first  = 1'b0;
    case (state)
      IDLE, DONE: begin
        accept = start_ok;
        first  = start_ok;
      end
      COLLECT: accept = s_in.in_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      n_q        <= '0;
      idx        <= '0;
      med_idx_q  <= '0;
      done       <= 1'b0;
      count      <= '0;
      max_val    <= '0;
      min_val    <= '0;
      median_val <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start_ok) begin
            n_q       <= s_in.n;
            idx       <= CNT_W'(1);
            med_idx_q <= start_med_idx;
            max_val   <= s_in.in_data;
            if (start_med_idx == '0) median_val <= s_in.in_data;
            if (s_in.n == CNT_W'(1)) begin
              // Single-element frame completes on acceptance.
              min_val <= s_in.in_data;
              count   <= CNT_W'(1);
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (s_in.in_valid) begin
            idx <= idx + CNT_W'(1);
            if (idx == med_idx_q) median_val <= s_in.in_data;
            if (idx == n_q - CNT_W'(1)) begin
              min_val <= s_in.in_data;
              count   <= n_q;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sort_stat_accum #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .SUM_W  (SUM_W)
  ) u_accum (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .first     (first),
    .idx       (first ? '0 : idx),
    .in_data   (s_in.in_data),
    .sum       (sum),
    .order_err (order_err),
    .err_index (err_index)
  );

endmodule

// File: tb/tb_sort_result_checker.sv
// tb_sort_result_checker: table-driven and randomized checks of sort_result_checker.
module tb_sort_result_checker;

  typedef logic [31:0] arr_t [16];

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] mx;
    logic [31:0] mn;
    logic [31:0] md;
    logic [63:0] sm;
    logic        er;
    logic [31:0] ei;
  } exp_t;

  typedef struct {
    string tag;
    int    n;
    arr_t  d;
    bit    gaps;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        done;
  logic [31:0] count, max_val, min_val, median_val, err_index;
  logic [63:0] sum;
  logic        order_err;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  sort_result_checker_if #(.DATA_W(32), .CNT_W(32)) bus ();

  sort_result_checker #(.DATA_W(32), .CNT_W(32), .SUM_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (bus.slave),
    .done       (done),
    .count      (count),
    .max_val    (max_val),
    .min_val    (min_val),
    .median_val (median_val),
    .sum        (sum),
    .order_err  (order_err),
    .err_index  (err_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: results follow directly from the frame contents.
  function automatic exp_t model(input int n, input arr_t d);
    exp_t e;
    e.cnt = n;
    e.mx  = d[0];
    e.mn  = d[n-1];
    e.md  = d[(n-1)/2];
    e.sm  = '0;
    e.er  = 1'b0;
    e.ei  = '0;
    for (int i = 0; i < n; i++) begin
      e.sm += {32'd0, d[i]};
      if (i > 0 && d[i] > d[i-1] && !e.er) begin
        e.er = 1'b1;
        e.ei = i;
      end
    end
    return e;
  endfunction

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.n        = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] v, input logic [31:0] nn);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.n        = nn;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic check_results(input string tag, input exp_t e);
    check({tag, ".done"},      {63'd0, done}, 64'd1);
    check({tag, ".count"},     {32'd0, count}, {32'd0, e.cnt});
    check({tag, ".max"},       {32'd0, max_val}, {32'd0, e.mx});
    check({tag, ".min"},       {32'd0, min_val}, {32'd0, e.mn});
    check({tag, ".median"},    {32'd0, median_val}, {32'd0, e.md});
    check({tag, ".sum"},       sum, e.sm);
    check({tag, ".order_err"}, {63'd0, order_err}, {63'd0, e.er});
    check({tag, ".err_index"}, {32'd0, err_index}, {32'd0, e.ei});
  endtask

  // Streams one frame; n is presented only on element 0, garbage elsewhere.
  task automatic run_frame(input string tag, input int n, input arr_t d,
                           input exp_t e, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        int g = $urandom_range(1, 3);
        for (int k = 0; k < g; k++) begin
          idle_cycle();
          check({tag, ".gap_done"}, {63'd0, done}, 64'd0);
        end
      end
      send(d[i], (i == 0) ? n : $urandom);
      if (i < n - 1) check({tag, ".early_done"}, {63'd0, done}, 64'd0);
    end
    check_results(tag, e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".done"},      {63'd0, done}, 64'd0);
    check({tag, ".count"},     {32'd0, count}, 64'd0);
    check({tag, ".max"},       {32'd0, max_val}, 64'd0);
    check({tag, ".min"},       {32'd0, min_val}, 64'd0);
    check({tag, ".median"},    {32'd0, median_val}, 64'd0);
    check({tag, ".sum"},       sum, 64'd0);
    check({tag, ".order_err"}, {63'd0, order_err}, 64'd0);
    check({tag, ".err_index"}, {32'd0, err_index}, 64'd0);
  endtask

  function automatic exp_t mk_exp(input int cnt, input logic [31:0] mx, input logic [31:0] mn,
                                  input logic [31:0] md, input logic [63:0] sm,
                                  input bit er, input int ei);
    exp_t e;
    e.cnt = cnt; e.mx = mx; e.mn = mn; e.md = md; e.sm = sm; e.er = er; e.ei = ei;
    return e;
  endfunction

  vec_t tbl [8];

  initial begin
    int   ds;
    arr_t d;
    exp_t e;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.n        = '0;

    tbl[0] = '{"n5_sorted", 5, '{0:9, 1:7, 2:7, 3:3, 4:1, default:0}, 1'b0,
               mk_exp(5, 9, 1, 7, 27, 0, 0)};
    tbl[1] = '{"n4_err", 4, '{0:8, 1:5, 2:6, 3:2, default:0}, 1'b0,
               mk_exp(4, 8, 2, 5, 21, 1, 2)};
    tbl[2] = '{"n1", 1, '{0:42, default:0}, 1'b0,
               mk_exp(1, 42, 42, 42, 42, 0, 0)};
    tbl[3] = '{"b2b_a", 3, '{0:3, 1:2, 2:1, default:0}, 1'b0,
               mk_exp(3, 3, 1, 2, 6, 0, 0)};
    tbl[4] = '{"b2b_b", 2, '{0:10, 1:4, default:0}, 1'b0,
               mk_exp(2, 10, 4, 10, 14, 0, 0)};
    tbl[5] = '{"n3_gaps", 3, '{0:3, 1:2, 2:1, default:0}, 1'b1,
               mk_exp(3, 3, 1, 2, 6, 0, 0)};
    tbl[6] = '{"n3_ascend", 3, '{0:1, 1:2, 2:3, default:0}, 1'b0,
               mk_exp(3, 1, 3, 2, 6, 1, 1)};
    tbl[7] = '{"n6_two_err", 6, '{0:5, 1:5, 2:9, 3:9, 4:1, 5:0, default:0}, 1'b0,
               mk_exp(6, 5, 0, 9, 29, 1, 2)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    idle_cycle();

    // Table vectors, streamed back-to-back (each frame starts while done is high)
    for (int t = 0; t < 8; t++) run_frame(tbl[t].tag, tbl[t].n, tbl[t].d, tbl[t].e, tbl[t].gaps);
    idle_cycle();
    check("after_table.done_low", {63'd0, done}, 64'd0);
    check("after_table.done_pulses", done_seen, 8);

    // n==0 is ignored
    ds = done_seen;
    for (int k = 0; k < 4; k++) send($urandom, 32'd0);
    idle_cycle();
    check("n0.no_done", done_seen, ds);
    check("n0.sum_held", sum, 64'd29);

    // Reset mid-frame: no done, all outputs clear
    send(32'd7, 32'd4);
    send(32'd6, $urandom);
    reset = 1'b0;
    ds = done_seen;
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset = 1'b1;
    idle_cycle();
    idle_cycle();
    check("midreset.no_done", done_seen, ds);

    // Maximum element values: sum carries past DATA_W
    d = '{0:32'hFFFF_FFFF, 1:32'hFFFF_FFFF, default:0};
    run_frame("max_vals", 2, d, mk_exp(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                       64'h1_FFFF_FFFE, 0, 0), 1'b0);
    idle_cycle();

    // Randomized frames against the reference model
    for (int f = 0; f < 40; f++) begin
      logic [31:0] q[$];
      int n;
      n = $urandom_range(1, 16);
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)));
      q.rsort();
      if (n > 1 && $urandom_range(0, 2) == 0) begin
        int k = $urandom_range(1, n - 1);
        logic [31:0] tmp = q[k];
        q[k] = q[k-1];
        q[k-1] = tmp;
      end
      d = '{default:0};
      for (int i = 0; i < n; i++) d[i] = q[i];
      e = model(n, d);
      run_frame($sformatf("rand%0d", f), n, d, e, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
